// File: rtl/l1_mem_arbiter_pkg.sv
// Shared memory-hierarchy sizing constants and the L1 arbiter state encodings.
// Imported by the arbiter top, its tie-break sub-module and the bench.
package l1_mem_arbiter_pkg;

  localparam int DMEM_BLOCK_ADDR_SIZE = 26;
  localparam int DBLOCK_SIZE_BITS     = 128;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_GNT_I  = 2'd1,
    ARB_GNT_DR = 2'd2,
    ARB_GNT_DW = 2'd3
  } arb_state_e;

  // lastGnt values: which cache was served most recently
  localparam logic [1:0] LAST_I = 2'd0;
  localparam logic [1:0] LAST_D = 2'd1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin tie-break: the requester not served last wins a tie.
// Purely combinational; gnt_o is one-hot ([0]=icache, [1]=dcache) or zero.
module rr_arbiter2
  import l1_mem_arbiter_pkg::*;
(
  input  logic       ireq_i,
  input  logic       dreq_i,
  input  logic [1:0] last_gnt_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    if (ireq_i && dreq_i) begin
      gnt_o = (last_gnt_i == LAST_I) ? 2'b10 : 2'b01;
    end else if (ireq_i) begin
      gnt_o = 2'b01;
    end else if (dreq_i) begin
      gnt_o = 2'b10;
    end
  end

endmodule

// File: rtl/l1_mem_arbiter.sv
// Arbitrates one shared memory port between icache reads and dcache reads/writebacks.
// One IDLE arbitration cycle per grant; the grant is held until memory signals completion.
module l1_mem_arbiter
  import l1_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = DMEM_BLOCK_ADDR_SIZE,
  parameter int BLOCK_W = DBLOCK_SIZE_BITS
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               iMemRen,
  input  logic [ADDR_W-1:0]  iBlockAddr,
  output logic               iMemReadReady,
  input  logic               dMemRen,
  input  logic               dMemWen,
  input  logic [ADDR_W-1:0]  dBlockAddr,
  input  logic [BLOCK_W-1:0] dMemDin,
  output logic               dMemReadReady,
  output logic               dMemWriteDone,
  output logic [BLOCK_W-1:0] memDout,
  output logic               memRen,
  output logic               memWen,
  output logic [ADDR_W-1:0]  memAddr,
  output logic [BLOCK_W-1:0] memDin,
  input  logic [BLOCK_W-1:0] memRdData,
  input  logic               memReadReady,
  input  logic               memWriteDone
);

  arb_state_e state_q;
  logic [1:0] last_gnt_q;
  logic [1:0] gnt;

  rr_arbiter2 u_rr (
    .ireq_i     (iMemRen),
    .dreq_i     (dMemRen | dMemWen),
    .last_gnt_i (last_gnt_q),
    .gnt_o      (gnt)
  );

  // Completion always returns to IDLE, so every grant is preceded by an arbitration cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ARB_IDLE;
      last_gnt_q <= LAST_I;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (gnt[1]) begin
            state_q <= dMemWen ? ARB_GNT_DW : ARB_GNT_DR;
          end else if (gnt[0]) begin
            state_q <= ARB_GNT_I;
          end
        end
        ARB_GNT_I: begin
          if (memReadReady) begin
            state_q    <= ARB_IDLE;
            last_gnt_q <= LAST_I;
          end
        end
        ARB_GNT_DR: begin
          if (memReadReady) begin
            state_q    <= ARB_IDLE;
            last_gnt_q <= LAST_D;
          end
        end
        ARB_GNT_DW: begin
          if (memWriteDone) begin
            state_q    <= ARB_IDLE;
            last_gnt_q <= LAST_D;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign memRen = (state_q == ARB_GNT_I) || (state_q == ARB_GNT_DR);
  assign memWen = (state_q == ARB_GNT_DW);

  always_comb begin
    memAddr = '0;
    case (state_q)
      ARB_GNT_I:              memAddr = iBlockAddr;
      ARB_GNT_DR, ARB_GNT_DW: memAddr = dBlockAddr;
      default:                memAddr = '0;
    endcase
  end

  assign memDin  = memWen ? dMemDin : '0;
  assign memDout = memRdData;

  assign iMemReadReady = (state_q == ARB_GNT_I)  && memReadReady;
  assign dMemReadReady = (state_q == ARB_GNT_DR) && memReadReady;
  assign dMemWriteDone = (state_q == ARB_GNT_DW) && memWriteDone;

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// Directed table-driven bench for l1_mem_arbiter: one table row per clock cycle,
// plus an asynchronous reset asserted in the middle of a writeback grant.
module tb_l1_mem_arbiter;
  import l1_mem_arbiter_pkg::*;

  localparam int AW = DMEM_BLOCK_ADDR_SIZE;
  localparam int BW = DBLOCK_SIZE_BITS;
  localparam int OW = 5 + AW + BW;

  localparam logic [AW-1:0] IA  = 26'h21;
  localparam logic [AW-1:0] DA  = 26'h31;
  localparam logic [AW-1:0] A12 = 26'h12;
  localparam logic [AW-1:0] A44 = 26'h44;
  localparam logic [AW-1:0] A55 = 26'h55;
  localparam logic [AW-1:0] A66 = 26'h66;
  localparam logic [BW-1:0] PAT = {(BW/16){16'hA5A5}};
  localparam logic [BW-1:0] NPAT = ~PAT;
  localparam logic [BW-1:0] Z = '0;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          iMemRen = 1'b0, dMemRen = 1'b0, dMemWen = 1'b0;
  logic [AW-1:0] iBlockAddr = '0, dBlockAddr = '0, memAddr;
  logic [BW-1:0] dMemDin = '0, memDout, memDin, memRdData = '0;
  logic          memReadReady = 1'b0, memWriteDone = 1'b0;
  logic          iMemReadReady, dMemReadReady, dMemWriteDone, memRen, memWen;

  l1_mem_arbiter dut (
    .clock         (clock),
    .reset         (reset),
    .iMemRen       (iMemRen),
    .iBlockAddr    (iBlockAddr),
    .iMemReadReady (iMemReadReady),
    .dMemRen       (dMemRen),
    .dMemWen       (dMemWen),
    .dBlockAddr    (dBlockAddr),
    .dMemDin       (dMemDin),
    .dMemReadReady (dMemReadReady),
    .dMemWriteDone (dMemWriteDone),
    .memDout       (memDout),
    .memRen        (memRen),
    .memWen        (memWen),
    .memAddr       (memAddr),
    .memDin        (memDin),
    .memRdData     (memRdData),
    .memReadReady  (memReadReady),
    .memWriteDone  (memWriteDone)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic          rst, ir, dr, dw;
    logic [AW-1:0] ia, da;
    logic [BW-1:0] dd;
    logic          rr, wd;
    logic          e_ren, e_wen;
    logic [AW-1:0] e_addr;
    logic [BW-1:0] e_din;
    logic          e_irdy, e_drdy, e_ddone;
  } vec_t;

  vec_t          vecs[$];
  string         names[$];
  int            total = 0;
  int            bad = 0;
  int            mid_at = 0;
  logic [BW-1:0] rd_q = '0;

  task automatic add(string n, logic rst, logic ir, logic dr, logic dw,
                     logic [AW-1:0] ia, logic [AW-1:0] da, logic [BW-1:0] dd,
                     logic rr, logic wd, logic er, logic ew,
                     logic [AW-1:0] ea, logic [BW-1:0] ed,
                     logic eir, logic edr, logic edd);
    vec_t v;
    v.rst = rst; v.ir = ir; v.dr = dr; v.dw = dw;
    v.ia = ia; v.da = da; v.dd = dd; v.rr = rr; v.wd = wd;
    v.e_ren = er; v.e_wen = ew; v.e_addr = ea; v.e_din = ed;
    v.e_irdy = eir; v.e_drdy = edr; v.e_ddone = edd;
    vecs.push_back(v);
    names.push_back(n);
  endtask

  task automatic cmp(string n, logic [OW-1:0] got, logic [OW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", n, got, exp);
    end
  endtask

  task automatic check_outputs(string n, vec_t v);
    cmp(n, {memRen, memWen, iMemReadReady, dMemReadReady, dMemWriteDone, memAddr, memDin},
           {v.e_ren, v.e_wen, v.e_irdy, v.e_drdy, v.e_ddone, v.e_addr, v.e_din});
    cmp({n, "_dout"}, {{(OW-BW){1'b0}}, memDout}, {{(OW-BW){1'b0}}, rd_q});
  endtask

  task automatic step(int i);
    vec_t v;
    v = vecs[i];
    @(negedge clock);
    reset = v.rst;
    iMemRen = v.ir; dMemRen = v.dr; dMemWen = v.dw;
    iBlockAddr = v.ia; dBlockAddr = v.da; dMemDin = v.dd;
    memReadReady = v.rr; memWriteDone = v.wd;
    rd_q = {$urandom, $urandom, $urandom, $urandom};
    memRdData = rd_q;
    #1;
    check_outputs(names[i], v);
  endtask

  task automatic mid_reset();
    vec_t zero_v;
    zero_v = vecs[0];
    #2;
    reset = 1'b0;
    #1;
    check_outputs("mid_dw_reset", zero_v);
  endtask

  initial begin
    //   name          rst ir dr dw  ia   da   dd    rr wd  ren wen addr din   ir dr dd
    add("rst0",        0, 0, 0, 0, '0,  '0,  Z,    0, 0,  0, 0, '0,  Z,    0, 0, 0);
    add("rst_ignore",  0, 1, 1, 0, IA,  DA,  Z,    1, 1,  0, 0, '0,  Z,    0, 0, 0);
    add("tie_idle",    1, 1, 1, 0, IA,  DA,  Z,    0, 0,  0, 0, '0,  Z,    0, 0, 0);
    add("tie_d_wait",  1, 1, 1, 0, IA,  DA,  Z,    0, 0,  1, 0, DA,  Z,    0, 0, 0);
    add("tie_d_done",  1, 1, 1, 0, IA,  DA,  Z,    1, 0,  1, 0, DA,  Z,    0, 1, 0);
    add("tie_gap",     1, 1, 0, 0, IA,  DA,  Z,    0, 0,  0, 0, '0,  Z,    0, 0, 0);
    add("tie_i_done",  1, 1, 0, 0, IA,  DA,  Z,    1, 0,  1, 0, IA,  Z,    1, 0, 0);
    for (int t = 0; t < 2; t++) begin
      add("rr_gap_d",  1, 1, 1, 0, IA,  DA,  Z,    0, 0,  0, 0, '0,  Z,    0, 0, 0);
      add("rr_d",      1, 1, 1, 0, IA,  DA,  Z,    1, 0,  1, 0, DA,  Z,    0, 1, 0);
      add("rr_gap_i",  1, 1, 1, 0, IA,  DA,  Z,    0, 0,  0, 0, '0,  Z,    0, 0, 0);
      add("rr_i",      1, 1, 1, 0, IA,  DA,  Z,    1, 0,  1, 0, IA,  Z,    1, 0, 0);
    end
    add("i_req",       1, 1, 0, 0, A12, DA,  Z,    0, 0,  0, 0, '0,  Z,    0, 0, 0);
    add("i_c2",        1, 1, 0, 0, A12, DA,  Z,    0, 0,  1, 0, A12, Z,    0, 0, 0);
    add("i_c3_wd",     1, 1, 0, 0, A12, DA,  Z,    0, 1,  1, 0, A12, Z,    0, 0, 0);
    add("i_c4_done",   1, 1, 0, 0, A12, DA,  Z,    1, 0,  1, 0, A12, Z,    1, 0, 0);
    add("i_after",     1, 0, 0, 0, A12, DA,  Z,    0, 0,  0, 0, '0,  Z,    0, 0, 0);
    add("spur",        1, 0, 0, 0, '0,  '0,  Z,    1, 1,  0, 0, '0,  Z,    0, 0, 0);
    add("spur_idle",   1, 0, 0, 0, '0,  '0,  Z,    0, 0,  0, 0, '0,  Z,    0, 0, 0);
    add("w_req",       1, 0, 0, 1, '0,  A44, PAT,  0, 0,  0, 0, '0,  Z,    0, 0, 0);
    add("w_c2",        1, 0, 0, 1, '0,  A44, PAT,  0, 0,  0, 1, A44, PAT,  0, 0, 0);
    add("w_c3_rr",     1, 0, 0, 1, '0,  A44, PAT,  1, 0,  0, 1, A44, PAT,  0, 0, 0);
    add("w_c4",        1, 0, 0, 1, '0,  A44, PAT,  0, 0,  0, 1, A44, PAT,  0, 0, 0);
    add("w_c5",        1, 0, 0, 1, '0,  A44, PAT,  0, 0,  0, 1, A44, PAT,  0, 0, 0);
    add("w_c6_done",   1, 0, 0, 1, '0,  A44, PAT,  0, 1,  0, 1, A44, PAT,  0, 0, 1);
    add("w_after",     1, 0, 0, 0, '0,  A44, PAT,  0, 0,  0, 0, '0,  Z,    0, 0, 0);
    add("rw_req",      1, 0, 1, 1, '0,  A66, NPAT, 0, 0,  0, 0, '0,  Z,    0, 0, 0);
    add("rw_is_write", 1, 0, 1, 1, '0,  A66, NPAT, 1, 1,  0, 1, A66, NPAT, 0, 0, 1);
    add("rw_after",    1, 0, 0, 0, '0,  A66, NPAT, 0, 0,  0, 0, '0,  Z,    0, 0, 0);
    add("w2_req",      1, 0, 0, 1, '0,  A55, PAT,  0, 0,  0, 0, '0,  Z,    0, 0, 0);
    add("w2_gnt",      1, 0, 0, 1, '0,  A55, PAT,  0, 0,  0, 1, A55, PAT,  0, 0, 0);
    mid_at = vecs.size();
    add("rst_hold0",   0, 1, 1, 0, IA,  DA,  Z,    0, 0,  0, 0, '0,  Z,    0, 0, 0);
    add("rst_hold1",   0, 1, 1, 0, IA,  DA,  Z,    1, 0,  0, 0, '0,  Z,    0, 0, 0);
    add("rel_idle",    1, 1, 1, 0, IA,  DA,  Z,    0, 0,  0, 0, '0,  Z,    0, 0, 0);
    add("post_d",      1, 1, 1, 0, IA,  DA,  Z,    1, 0,  1, 0, DA,  Z,    0, 1, 0);
    add("post_gap",    1, 1, 0, 0, IA,  DA,  Z,    0, 0,  0, 0, '0,  Z,    0, 0, 0);
    add("post_i",      1, 1, 0, 0, IA,  DA,  Z,    1, 0,  1, 0, IA,  Z,    1, 0, 0);
    add("end_idle",    1, 0, 0, 0, '0,  '0,  Z,    0, 0,  0, 0, '0,  Z,    0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      if (i == mid_at) mid_reset();
      step(i);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/l1_mem_arbiter.md
L1_MEM_ARBITER -- requirements
Module: l1_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default `DMEM_BLOCK_ADDR_SIZE, block-address width shared by both caches and memory.
REQ-002 Parameter BLOCK_W, default `DBLOCK_SIZE_BITS, block data width shared by both caches and memory.
REQ-003 clock  input  1  rising-edge system clock.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 iMemRen  input  1  icache miss read request, held high until iMemReadReady.
REQ-006 iBlockAddr  input  ADDR_W  icache block address.
REQ-007 iMemReadReady  output  1  read-complete pulse to icache.
REQ-008 dMemRen  input  1  dcache read request, held until dMemReadReady.
REQ-009 dMemWen  input  1  dcache writeback request, held until dMemWriteDone.
REQ-010 dBlockAddr  input  ADDR_W  dcache block address.
REQ-011 dMemDin  input  BLOCK_W  dcache writeback data.
REQ-012 dMemReadReady, dMemWriteDone  output  1 each  completion pulses to dcache.
REQ-013 memDout  output  BLOCK_W  memory read data, broadcast unregistered to both caches.
REQ-014 memRen, memWen  output  1 each  memory requests.
REQ-015 memAddr  output  ADDR_W; memDin  output  BLOCK_W  memory address/write data.
REQ-016 memRdData  input  BLOCK_W; memReadReady, memWriteDone  input  1 each  memory responses.

Function
REQ-017 States: IDLE, GNT_I (icache read), GNT_DR (dcache read), GNT_DW (dcache write); 2-bit register lastGnt tracks the last requester served (0=icache, 1=dcache).
REQ-018 IDLE: no request -> stay IDLE; exactly one requester -> grant it at next edge.
REQ-019 IDLE, both iMemRen and (dMemRen|dMemWen) high -> grant the requester not equal to lastGnt (round-robin).
REQ-020 dMemRen and dMemWen both high -> dcache request is treated as write (GNT_DW).
REQ-021 In IDLE, memRen=memWen=0, memAddr=0, memDin=0; arbitration costs exactly one cycle before memory sees a request.
REQ-022 GNT_I: memRen=1, memAddr=iBlockAddr; GNT_DR: memRen=1, memAddr=dBlockAddr; GNT_DW: memWen=1, memAddr=dBlockAddr, memDin=dMemDin.
REQ-023 Grant held unchanged until the matching completion input (memReadReady for reads, memWriteDone for writes) is sampled high.
REQ-024 Completion routed combinationally, same cycle, only to the granted requester's ready/done output; all other completion outputs 0.
REQ-025 On completion edge: next state IDLE, lastGnt updated to the served requester; no back-to-back grant without an IDLE cycle.
REQ-026 memReadReady/memWriteDone high in IDLE or in a mismatched grant state are ignored.
REQ-027 memDout = memRdData at all times; caches qualify it with their ready pulse.
REQ-028 Requester dropping its request before completion is illegal; arbiter keeps grant (no abort).

Reset
REQ-029 reset low asynchronously forces IDLE, lastGnt=0 (dcache wins first tie), and all outputs except memDout to 0, including mid-transaction.
REQ-030 After reset release, first grant occurs no earlier than the first rising edge with reset high.

Structure
REQ-031 State encodings ARB_IDLE, ARB_GNT_I, ARB_GNT_DR, ARB_GNT_DW go in the shared constants include alongside the cache size constants.
REQ-032 Tie-break logic is one sub-module rr_arbiter2 (two request inputs, lastGnt input, one-hot grant output), combinational only.
REQ-033 FSM state and lastGnt are the only registers; all outputs are decoded from state.

Verification
REQ-034 iMemRen alone, addr 0x12, memReadReady after 3 cycles -> memRen high cycles 2-4, memAddr=0x12, one-cycle iMemReadReady, dMemReadReady stays 0.
REQ-035 iMemRen and dMemRen rise together after reset -> dcache granted first; icache granted after one IDLE cycle following dMemReadReady.
REQ-036 Both repeatedly requesting for 4 transactions -> grants alternate D,I,D,I.
REQ-037 dMemWen, dMemDin=0xA5A5..., memWriteDone after 5 cycles -> memWen=1, memDin matches, single dMemWriteDone pulse, memRen never asserted.
REQ-038 Spurious memReadReady in IDLE -> no ready outputs pulse, state stays IDLE.
REQ-039 reset asserted mid-GNT_DW -> memWen and memAddr drop to 0 immediately; state IDLE; lastGnt=0.
